// File: rtl/mult_pkg.sv
// Shared definitions for the 12x12 shift-add multiplier: controller state encoding,
// default operand width and the counter width shared with the serial operand loaders.
package mult_pkg;

    localparam int WIDTH_DEF = 12;
    localparam int OP_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_OPS = 3'd1,
        LOAD    = 3'd2,
        RUN     = 3'd3,
        OUTPUT  = 3'd4,
        FINISH  = 3'd5
    } mult_state_e;

    function automatic logic is_wait_state(input mult_state_e s);
        return (s == GET_OPS) || (s == OUTPUT);
    endfunction

endpackage

// File: rtl/mult_ctrl_if.sv
// Handshake bundle between the multiplier controller and its loaders/datapath.
// slave is the controller side; master is the loader/datapath side.
interface mult_ctrl_if;

    logic go;
    logic fx;
    logic fy;
    logic m_lsb;
    logic fp;
    logic sx;
    logic sy;
    logic ld;
    logic add;
    logic shr;
    logic sp;
    logic busy;
    logic done;
    logic err;

    modport master (
        output go, fx, fy, m_lsb, fp,
        input  sx, sy, ld, add, shr, sp, busy, done, err
    );

    modport slave (
        input  go, fx, fy, m_lsb, fp,
        output sx, sy, ld, add, shr, sp, busy, done, err
    );

endinterface

// File: rtl/mult_iter_cnt.sv
// Loadable up-counter with clear, enable and a terminal-count flag; used for the
// add/shift iteration count and for the optional wait timeout.
module mult_iter_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term_val,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins over load, load wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == term_val);

endmodule

// File: rtl/mult_ctrl.sv
// Sequencing controller for the 12x12 unsigned shift-add multiplier.
// Build macro MULT_CTRL_TIMEOUT_EN adds a GET_OPS/OUTPUT wait timeout with sticky err.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CNT_W   = OP_CNT_W,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    mult_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

    if (((2 ** CNT_W) < WIDTH) || (TIMEOUT < 1)) begin : g_bad_params
        $error("mult_ctrl: CNT_W too narrow for WIDTH, or TIMEOUT below 1");
    end

    mult_state_e state_q;
    mult_state_e state_d;
    logic        go_q;
    logic        fx_seen_q, fx_seen_d;
    logic        fy_seen_q, fy_seen_d;
    logic        sx_q, sx_d;
    logic        sy_q, sy_d;
    logic        ld_q, ld_d;
    logic        shr_q, shr_d;
    logic        sp_q, sp_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        go_edge_s;
    logic        both_seen_s;
    logic        iter_tc_s;
    logic        wait_exp_s;

    assign go_edge_s   = bus.go & ~go_q;
    assign both_seen_s = (fx_seen_q | bus.fx) & (fy_seen_q | bus.fy);

    // Holds at WIDTH-1 once reached so the count cannot wrap inside a run.
    mult_iter_cnt #(.W(CNT_W)) u_iter_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_q == LOAD),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .en       ((state_q == RUN) & ~iter_tc_s),
        .term_val (ITER_LAST),
        .tc       (iter_tc_s)
    );

`ifdef MULT_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic waiting_s;
    logic wait_tc_s;
    logic err_q, err_d;

    assign waiting_s = is_wait_state(state_q);

    // Wait states are never adjacent, so clearing outside them clears on every state change.
    mult_iter_cnt #(.W(TO_W)) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (~waiting_s),
        .load     (1'b0),
        .load_val ({TO_W{1'b0}}),
        .en       (waiting_s),
        .term_val (TO_LAST),
        .tc       (wait_tc_s)
    );

    assign wait_exp_s = waiting_s & wait_tc_s;

    // Sticky timeout flag; only an accepted go edge clears it.
    always_comb begin
        if ((state_q == IDLE) && go_edge_s) begin
            err_d = 1'b0;
        end else if (wait_exp_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Timeout flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign wait_exp_s = 1'b0;
    assign bus.err    = 1'b0;
`endif

    // Next state, done-flag latches, and output decode from the next state.
    always_comb begin
        state_d   = state_q;
        fx_seen_d = fx_seen_q;
        fy_seen_d = fy_seen_q;
        case (state_q)
            IDLE: begin
                if (go_edge_s) begin
                    state_d   = GET_OPS;
                    fx_seen_d = 1'b0;
                    fy_seen_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            GET_OPS: begin
                fx_seen_d = fx_seen_q | bus.fx;
                fy_seen_d = fy_seen_q | bus.fy;
                if (both_seen_s) begin
                    state_d = LOAD;
                end else if (wait_exp_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GET_OPS;
                end
            end
            LOAD: begin
                fx_seen_d = 1'b0;
                fy_seen_d = 1'b0;
                state_d   = RUN;
            end
            RUN: begin
                if (iter_tc_s) begin
                    state_d = OUTPUT;
                end else begin
                    state_d = RUN;
                end
            end
            OUTPUT: begin
                if (bus.fp) begin
                    state_d = FINISH;
                end else if (wait_exp_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUTPUT;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                fx_seen_d = 1'b0;
                fy_seen_d = 1'b0;
            end
        endcase

        sx_d   = (state_d == GET_OPS);
        sy_d   = (state_d == GET_OPS);
        ld_d   = (state_d == LOAD);
        shr_d  = (state_d == RUN);
        sp_d   = (state_d == OUTPUT);
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    // FSM state, go edge detector, seen latches and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            go_q      <= 1'b0;
            fx_seen_q <= 1'b0;
            fy_seen_q <= 1'b0;
            sx_q      <= 1'b0;
            sy_q      <= 1'b0;
            ld_q      <= 1'b0;
            shr_q     <= 1'b0;
            sp_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_q      <= bus.go;
            fx_seen_q <= fx_seen_d;
            fy_seen_q <= fy_seen_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            ld_q      <= ld_d;
            shr_q     <= shr_d;
            sp_q      <= sp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sx   = sx_q;
    assign bus.sy   = sy_q;
    assign bus.ld   = ld_q;
    assign bus.shr  = shr_q;
    assign bus.add  = shr_q & bus.m_lsb;
    assign bus.sp   = sp_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl: drives loader/product handshakes, models the datapath
// multiplier register feeding m_lsb, and scoreboards each operation's strobe pattern.
module tb_mult_ctrl;
    import mult_pkg::*;

    typedef struct {
        int         shr_cycles;
        logic [11:0] add_mask;
        int         ld_pulses;
    } exp_t;

`ifdef MULT_CTRL_TIMEOUT_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 255;
`endif

    logic        clk;
    logic        reset;
    logic [11:0] mval;
    logic [11:0] mreg_q;
    logic [11:0] mon_mask;
    logic [11:0] a05_mask;
    int          mon_shr;
    int          mon_ld;
    int          checks;
    int          errors;
    exp_t        sb_q[$];

    mult_ctrl_if bus ();

    mult_ctrl #(.WIDTH(12), .CNT_W(4), .TIMEOUT(TB_TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath multiplier register: loaded on ld, shifted right on shr.
    assign bus.m_lsb = mreg_q[0];
    always @(posedge clk or posedge reset) begin
        if (reset)        mreg_q <= 12'h000;
        else if (bus.ld)  mreg_q <= mval;
        else if (bus.shr) mreg_q <= {1'b0, mreg_q[11:1]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: accumulates per-operation strobes, compares against the scoreboard on done.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            mon_shr  = 0;
            mon_ld   = 0;
            mon_mask = 12'h000;
        end else begin
            if (bus.ld) mon_ld++;
            if (bus.shr) begin
                if (mon_shr < 12) mon_mask[mon_shr] = bus.add;
                mon_shr++;
            end
            if (bus.done) begin
                check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("shr_cycles", mon_shr, e.shr_cycles);
                    check("add_mask", mon_mask, e.add_mask);
                    check("ld_pulses", mon_ld, e.ld_pulses);
                end
                mon_shr  = 0;
                mon_ld   = 0;
                mon_mask = 12'h000;
            end
        end
    end

    task automatic op_start(input logic [11:0] m, input int fxd, input int fyd,
                            input bit hold_go, input logic [11:0] exp_mask);
        exp_t e;
        int   last;
        mval         = m;
        e.shr_cycles = 12;
        e.add_mask   = exp_mask;
        e.ld_pulses  = 1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("go_to_getops", {bus.sx, bus.sy, bus.busy, bus.ld}, 4'b1110);
        if (!hold_go) bus.go = 1'b0;
        last = (fxd > fyd) ? fxd : fyd;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            if (c == fxd) bus.fx = 1'b1;
            if (c == fyd) bus.fy = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("ld_after_both", {bus.ld, bus.sx, bus.shr}, 3'b100);
        bus.fx = 1'b0;
        bus.fy = 1'b0;
    endtask

    task automatic wait_sp(input bit toggle_go);
        int n = 0;
        while (!bus.sp && n < 40) begin
            @(negedge clk);
            n++;
            if (toggle_go && n == 4) bus.go = 1'b1;
            if (toggle_go && n == 6) bus.go = 1'b0;
        end
        check("sp_latency", n, 13);
    endtask

    task automatic op_end(input int fpd);
        for (int c = 1; c <= fpd; c++) begin
            @(posedge clk); #1;
            if (c == fpd) bus.fp = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("done_after_fp", {bus.done, bus.busy, bus.sp}, 3'b110);
        bus.fp = 1'b0;
        @(negedge clk);
        check("busy_drop", {bus.done, bus.busy}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        bus.go   = 1'b0;
        bus.fx   = 1'b0;
        bus.fy   = 1'b0;
        bus.fp   = 1'b0;
        mval     = 12'h000;
        a05_mask = 12'h000;
        a05_mask[0]  = 1'b1;
        a05_mask[2]  = 1'b1;
        a05_mask[9]  = 1'b1;
        a05_mask[11] = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.sx, bus.sy, bus.ld, bus.add, bus.shr, bus.sp,
                                bus.busy, bus.done, bus.err}, 9'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {bus.busy, bus.sx}, 2'b00);

        // fx after 3, fy after 5, fp 2 cycles after sp; multiplier A05
        op_start(12'hA05, 3, 5, 1'b0, a05_mask);
        wait_sp(1'b0);
        op_end(2);

        // fx and fy in the same cycle
        op_start(12'h3C7, 1, 1, 1'b0, 12'h3C7);
        wait_sp(1'b0);
        op_end(1);

        // go held high through completion must not retrigger
        op_start(12'hFFF, 2, 1, 1'b1, 12'hFFF);
        wait_sp(1'b0);
        op_end(3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_retrigger", bus.busy, 1'b0);
        end
        bus.go = 1'b0;

        // go toggled mid-RUN is ignored and not queued
        op_start(12'h001, 4, 2, 1'b0, 12'h001);
        wait_sp(1'b1);
        op_end(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("toggle_ignored", bus.busy, 1'b0);
        end

        // reset in RUN iteration 5 clears everything without a clock edge
        op_start(12'h5A3, 2, 2, 1'b0, 12'h5A3);
        repeat (6) @(negedge clk);
        check("in_run_iter5", bus.shr, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("reset_async", {bus.sx, bus.sy, bus.ld, bus.add, bus.shr, bus.sp,
                              bus.busy, bus.done, bus.err}, 9'b0);
        sb_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;

        // full sequence after the mid-run reset
        op_start(12'h800, 1, 3, 1'b0, 12'h800);
        wait_sp(1'b0);
        op_end(2);

`ifdef MULT_CTRL_TIMEOUT_EN
        begin
            int n = 0;
            @(posedge clk); #1;
            bus.go = 1'b1;
            @(posedge clk); #1;
            bus.go = 1'b0;
            bus.fx = 1'b1;
            @(negedge clk);
            while (bus.busy && n < 100) begin
                n++;
                @(negedge clk);
            end
            check("timeout_cycles", n, 16);
            check("timeout_err", {bus.err, bus.done, bus.busy}, 3'b100);
            bus.fx = 1'b0;
            @(posedge clk); #1;
            bus.go = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("err_cleared", {bus.err, bus.busy}, 2'b01);
            bus.go = 1'b0;
            repeat (20) @(negedge clk);
            check("timeout_again", {bus.err, bus.busy}, 2'b10);
        end
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Sequencing controller for the 12x12 unsigned shift-add multiplier. It starts the two serial operand loaders, waits for both done flags, and loads the datapath. It then runs WIDTH add/shift iterations, starts the serial product output, and reports completion. The block holds control state only (FSM, iteration counter, done-flag latches); operand and product registers belong to the datapath.

## Interface
Parameters:
- WIDTH, 12, operand width and number of add/shift iterations
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W >= WIDTH
- TIMEOUT, 255, maximum wait cycles in GET_OPS/OUTPUT (used only with the timeout feature)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- go  in  1  start request; only a rising edge is acted on
- fx  in  1  X operand loader done flag (level)
- fy  in  1  Y operand loader done flag (level)
- m_lsb  in  1  current LSB of the datapath multiplier register
- fp  in  1  product shift-out done flag (level)
- sx  out  1  start X loader (level)
- sy  out  1  start Y loader (level)
- ld  out  1  load operands into datapath, clear accumulator
- add  out  1  add multiplicand into upper accumulator this cycle
- shr  out  1  shift accumulator/multiplier right by 1 this cycle
- sp  out  1  start product shift-out (level)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  timeout flag (sticky)

## Operation
- FSM states: IDLE, GET_OPS, LOAD, RUN, OUTPUT, FINISH.
- IDLE: all strobes low. A go edge (go=1 and the registered go=0) moves to GET_OPS and clears err.
- GET_OPS: sx=sy=1. fx and fy are latched independently into fx_seen and fy_seen, in any order or together. When both are seen, or both arrive in the same cycle, the next state is LOAD.
- LOAD: ld=1 for exactly one cycle. Clears the counter and both seen latches.
- RUN: shr=1 every cycle and add=m_lsb combinationally. The counter increments each cycle. At count==WIDTH-1 the next state is OUTPUT.
- OUTPUT: sp=1 until fp=1, then FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- A go edge while busy is ignored and not queued. go still held high on return to IDLE does not retrigger; a fresh low-to-high edge is required.
- sx, sy and sp are driven low in IDLE, so each operation presents a fresh rising edge to the loaders.
- Counter width rule: the counter compares against WIDTH-1 in CNT_W bits and never wraps within a run.

## Timing
- Reset values: sx=sy=ld=add=shr=sp=busy=done=err=0; state IDLE; count 0; seen latches 0. Reset asserted mid-operation returns the block to these values immediately, without waiting for a clock.
- go edge sampled at edge N: sx/sy/busy high from cycle N+1.
- Both fx and fy seen at edge M: ld high in cycle M+1; RUN occupies cycles M+2 .. M+1+WIDTH.
- sp rises in cycle M+2+WIDTH.
- fp sampled high at edge P: done is high in cycle P+1; busy falls in cycle P+2.
- Minimum latency from go edge to done is 1 + 1 + WIDTH + 1 + 1 cycles (GET_OPS, LOAD, RUN, OUTPUT, FINISH), given fx, fy and fp each returning in one cycle.
- All outputs are decoded from registered state. add is the only output with a combinational input term (m_lsb).

## Configuration
- MULT_CTRL_TIMEOUT_EN defined: a wait counter runs in GET_OPS and OUTPUT and is cleared on every state change. When it reaches TIMEOUT, the FSM returns to IDLE and err=1; done is not pulsed. err stays high until the next accepted go edge.
- MULT_CTRL_TIMEOUT_EN undefined: GET_OPS and OUTPUT wait indefinitely. err is tied to 0, and no wait counter is synthesized.

## Structure
- Shared package mult_pkg: state enumeration (IDLE..FINISH), WIDTH default constant, and an OP_CNT_W constant used by both this block and the operand loaders.
- One sub-module, mult_iter_cnt: a loadable up-counter with clear, enable and a terminal-count output, reused for the iteration counter and the timeout counter.

## Test plan
- Reset release, then go 0->1, fx at +3 cycles, fy at +5 cycles, fp at +2 cycles after sp -> ld pulses once after fy; shr high for exactly 12 cycles; done pulses once; busy drops 1 cycle after done.
- Multiplier 12'hA05 presented LSB-first on m_lsb -> add high in RUN iterations 0, 2, 9 and 11 only.
- fx and fy asserted in the same cycle -> ld in the next cycle.
- go held high through completion -> no second operation. go toggled mid-RUN -> ignored, with exactly one done.
- reset asserted in RUN iteration 5 -> all outputs 0 immediately; a subsequent go edge runs a full 12-iteration sequence.
- MULT_CTRL_TIMEOUT_EN with TIMEOUT=16 and fy never asserted -> return to IDLE after 16 GET_OPS cycles, err=1, no done; the next go edge clears err.
